note_sequencer: RTL and testbench

Queues note commands (tune word, volume, duration) delivered from the SPI receiver and plays them one at a time into the waveform generator and volume multiplier. Applies a linear attack/sustain/release volume envelope so notes start and stop without clicks. All envelope and scheduling state advances only on the 156.25 kHz wave-generator strobe. Sits between the SPI receiver and the waveGen/volumeMult pair in the top level.

---
 rtl/note_sequencer.sv | 155 +++++++++++++++
 tb/tb_note_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note command queue feeding the wave generator, with a linear attack/sustain/release
// volume envelope stepped on the wave-generator tick strobe.
module note_sequencer #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  RAMP_STEP = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        noteValid,
    input  logic [15:0] noteTune,
    input  logic [7:0]  noteVol,
    input  logic [15:0] noteDur,
    output logic        noteReady,
    output logic [15:0] tuneWord,
    output logic [7:0]  volume,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [39:0]   fifo_q [DEPTH];
    logic [39:0]   fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   tune_q, tune_d;
    logic [7:0]    vol_q, vol_d;
    logic [7:0]    target_q, target_d;
    logic [15:0]   dur_q, dur_d;
    logic [15:0]   dur_cnt_q, dur_cnt_d;
    logic          overflow_q, overflow_d;

    logic          push, pop, fifo_empty;
    logic [39:0]   head;
    logic [8:0]    sum9;

    assign noteReady = (count_q != CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign push       = noteValid && noteReady;

    assign tuneWord = tune_q;
    assign volume   = vol_q;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tune_d     = tune_q;
        vol_d      = vol_q;
        target_d   = target_q;
        dur_d      = dur_q;
        dur_cnt_d  = dur_cnt_q;
        overflow_d = overflow_q;
        pop        = 1'b0;
        sum9       = {1'b0, vol_q} + {1'b0, RAMP_STEP};

        if (push) begin
            fifo_d[wr_ptr_q] = {noteTune, noteVol, noteDur};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (noteValid && !noteReady) overflow_d = 1'b1;

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    vol_d = 8'd0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    // Clamp in 9 bits so a target near 255 never wraps past it.
                    if (sum9 >= {1'b0, target_q}) begin
                        vol_d     = target_q;
                        dur_cnt_d = dur_q;
                        state_d   = S_SUSTAIN;
                    end else begin
                        vol_d = sum9[7:0];
                    end
                end
                S_SUSTAIN: begin
                    if (dur_cnt_q == 16'd0) state_d   = S_RELEASE;
                    else                    dur_cnt_d = dur_cnt_q - 16'd1;
                end
                S_RELEASE: begin
                    if (vol_q > RAMP_STEP) begin
                        vol_d = vol_q - RAMP_STEP;
                    end else begin
                        vol_d = 8'd0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = S_ATTACK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (pop) begin
            tune_d   = head[39:24];
            target_d = head[23:16];
            dur_d    = head[15:0];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tune_q     <= '0;
            vol_q      <= '0;
            target_q   <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tune_q     <= tune_d;
            vol_q      <= vol_d;
            target_q   <= target_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: reset, envelope shapes, FIFO overflow,
// back-to-back playback and reset during a note.
`timescale 1ns/1ps
module tb_note_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        noteValid = 1'b0;
    logic [15:0] noteTune = '0;
    logic [7:0]  noteVol = '0;
    logic [15:0] noteDur = '0;
    logic        noteReady;
    logic [15:0] tuneWord;
    logic [7:0]  volume;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    note_sequencer #(.DEPTH(4), .RAMP_STEP(8'd4)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .noteValid(noteValid), .noteTune(noteTune), .noteVol(noteVol), .noteDur(noteDur),
        .noteReady(noteReady), .tuneWord(tuneWord), .volume(volume),
        .busy(busy), .overflow(overflow)
    );

    always #12.5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick = 1'b0;
        noteValid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
    endtask

    task automatic push(input logic [15:0] t, input logic [7:0] v, input logic [15:0] d);
        noteTune = t;
        noteVol = v;
        noteDur = d;
        noteValid = 1'b1;
        step();
        noteValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if (tuneWord !== 16'h0 || volume !== 8'h0 || busy !== 1'b0 || overflow !== 1'b0 || noteReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got tune=%h vol=%h busy=%b ovf=%b rdy=%b, want 0 0 0 0 1",
                     tuneWord, volume, busy, overflow, noteReady);
        end
        tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (tuneWord !== 16'h0 || volume !== 8'h0 || busy !== 1'b0 || overflow !== 1'b0 || noteReady !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold tick %0d: got tune=%h vol=%h busy=%b ovf=%b rdy=%b, want 0 0 0 0 1",
                         i, tuneWord, volume, busy, overflow, noteReady);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_single_note();
        logic [7:0] exp_v [12];
        exp_v = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd12, 8'd8, 8'd4, 8'd0};
        apply_reset();
        tick = 1'b1;
        push(16'h0A3D, 8'h10, 16'd3);
        checks++;
        if (busy !== 1'b0 || tuneWord !== 16'h0) begin
            errors++;
            $display("FAIL single_no_pop_on_push: got busy=%b tune=%h, want 0 0000", busy, tuneWord);
        end
        step();
        checks++;
        if (tuneWord !== 16'h0A3D || busy !== 1'b1 || volume !== 8'd0) begin
            errors++;
            $display("FAIL single_pop: got tune=%h busy=%b vol=%0d, want 0a3d 1 0", tuneWord, busy, volume);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (volume !== exp_v[i]) begin
                errors++;
                $display("FAIL single_env tick %0d: got %0d want %0d", i, volume, exp_v[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || tuneWord !== 16'h0A3D) begin
            errors++;
            $display("FAIL single_end: got busy=%b tune=%h, want 0 0a3d", busy, tuneWord);
        end
        tick = 1'b0;
    endtask

    task automatic test_saturating_ramp();
        logic [7:0] exp_v [7];
        exp_v = '{8'd4, 8'd8, 8'd10, 8'd10, 8'd6, 8'd2, 8'd0};
        apply_reset();
        tick = 1'b1;
        push(16'h0123, 8'h0A, 16'd0);
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (volume !== exp_v[i]) begin
                errors++;
                $display("FAIL sat_env tick %0d: got %0d want %0d", i, volume, exp_v[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_end_busy: got %b want 0", busy);
        end
        tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_v [12];
        logic        exp_b [12];
        exp_v = '{8'd4, 8'd8, 8'd8, 8'd8, 8'd4, 8'd0, 8'd4, 8'd8, 8'd8, 8'd8, 8'd4, 8'd0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        push(16'h1000, 8'd8, 16'd1);
        push(16'h2000, 8'd8, 16'd1);
        tick = 1'b1;
        step();
        checks++;
        if (tuneWord !== 16'h1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop_a: got tune=%h busy=%b, want 1000 1", tuneWord, busy);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (volume !== exp_v[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_env tick %0d: got vol=%0d busy=%b, want %0d %b",
                         i, volume, busy, exp_v[i], exp_b[i]);
            end
            if (i == 5) begin
                checks++;
                if (tuneWord !== 16'h2000) begin
                    errors++;
                    $display("FAIL b2b_switch_tune: got %h want 2000", tuneWord);
                end
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] seen [8];
        logic [15:0] prev;
        int n_seen;
        for (int i = 0; i < 8; i++) seen[i] = '0;
        n_seen = 0;
        apply_reset();
        tick = 1'b1;
        push(16'h00F0, 8'd4, 16'd20);
        step();
        step();
        tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'h0101 + 16'(i), 8'd8, 16'd0);
            if (i == 2) begin
                checks++;
                if (noteReady !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_ready_after_3: got %b want 1", noteReady);
                end
            end
        end
        checks++;
        if (noteReady !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: got rdy=%b ovf=%b, want 0 0", noteReady, overflow);
        end
        push(16'h0105, 8'd8, 16'd0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_set: got %b want 1", overflow);
        end
        tick = 1'b1;
        prev = tuneWord;
        for (int c = 0; c < 400; c++) begin
            step();
            if (tuneWord !== prev) begin
                if (n_seen < 8) seen[n_seen] = tuneWord;
                n_seen++;
                prev = tuneWord;
            end
            if (busy === 1'b0) break;
        end
        checks++;
        if (busy !== 1'b0 || n_seen != 4) begin
            errors++;
            $display("FAIL ovf_play_count: got busy=%b notes=%0d, want 0 4", busy, n_seen);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== 16'h0101 + 16'(i)) begin
                errors++;
                $display("FAIL ovf_order %0d: got %h want %h", i, seen[i], 16'h0101 + 16'(i));
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_hold: got %b want 1", overflow);
        end
        tick = 1'b0;
    endtask

    task automatic test_reset_mid_sustain();
        apply_reset();
        tick = 1'b1;
        push(16'h0777, 8'd4, 16'd50);
        step();
        step();
        step();
        tick = 1'b0;
        push(16'h0888, 8'd8, 16'd0);
        push(16'h0999, 8'd8, 16'd0);
        checks++;
        if (volume !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got vol=%0d busy=%b, want 4 1", volume, busy);
        end
        #5;
        reset = 1'b0;
        #1;
        checks++;
        if (volume !== 8'd0 || busy !== 1'b0 || noteReady !== 1'b1 || tuneWord !== 16'h0) begin
            errors++;
            $display("FAIL midrst_immediate: got vol=%0d busy=%b rdy=%b tune=%h, want 0 0 1 0000",
                     volume, busy, noteReady, tuneWord);
        end
        repeat (3) step();
        reset = 1'b1;
        tick = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy !== 1'b0 || volume !== 8'd0 || tuneWord !== 16'h0) begin
                checks++;
                errors++;
                $display("FAIL midrst_after cycle %0d: got busy=%b vol=%0d tune=%h, want 0 0 0000",
                         i, busy, volume, tuneWord);
                break;
            end
        end
        checks++;
        if (busy !== 1'b0 || tuneWord !== 16'h0) begin
            errors++;
            $display("FAIL midrst_final: got busy=%b tune=%h, want 0 0000", busy, tuneWord);
        end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_saturating_ramp();
        test_back_to_back();
        test_overflow();
        test_reset_mid_sustain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
